// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the load/store sequencer (dmem_lsu_ctrl) and its
// lane aligner (dmem_lane_align):
//   - RV32I funct3 size/sign codes
//   - sequencer state type
//   - legality / misalignment / address-alignment helpers
// Optional feature macro used by the consumers: DMEM_LSU_MISALIGN_TRAP_EN
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_WR  = 2'd2,
    DONE    = 2'd3
  } lsu_state_t;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: f3_misaligned = addr_lo[0];
      F3_W:        f3_misaligned = (addr_lo != 2'b00);
      default:     f3_misaligned = 1'b0;
    endcase
  endfunction

  // Clears the address bits below the access size.
  function automatic logic [1:0] f3_align_lo(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: f3_align_lo = {addr_lo[1], 1'b0};
      F3_W:        f3_align_lo = 2'b00;
      default:     f3_align_lo = addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align (combinational)
// Byte-lane steering shared by the load path and the read-modify-write path.
// Ports:
//   word     in  32  memory word (registered read data)
//   addr_lo  in  2   byte offset within the word
//   funct3   in  3   size/sign code
//   wdata    in  16  right-aligned store data (only the low half is ever used)
//   load_val out 32  selected lane, sign/zero extended (word passes through)
//   merged   out 32  word with the addressed byte/half replaced by wdata
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wdata_rep;
  logic [3:0]  lane_en;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'h0, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'h0, half_sel};
      default: load_val = word;
    endcase
  end

  // Replicate the store data across all lanes, then let the per-lane enable
  // decide which lanes take it. Word stores never go through the merge.
  assign wdata_rep = funct3[0] ? {2{wdata}} : {4{wdata[7:0]}};

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_en[gi] = (funct3[1:0] == 2'b00) ? (addr_lo == LANE) :
                         (funct3[1:0] == 2'b01) ? (addr_lo[1] == LANE[1]) : 1'b0;
    assign merged[gi*8 +: 8] = lane_en[gi] ? wdata_rep[gi*8 +: 8] : word[gi*8 +: 8];
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl
// Load/store sequencer between the core memory stage and a synchronous
// word-wide data memory (write on the edge, read data registered one cycle).
// Byte addresses map to word addresses modulo the memory depth; sub-word
// stores are done as read-modify-write; sub-word loads are lane-selected and
// extended. Latency: load and SW respond one cycle after acceptance, SB/SH
// three cycles after; illegal accesses respond one cycle after with resp_err.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_we, req_funct3           store flag, RV32I size/sign code
//   req_addr, req_wdata          byte address, right-aligned store data
//   resp_valid/rdata/err         one-cycle completion pulse and load data
//   mem_addr, mem_wr_dat,
//   mem_wr_en, mem_rd_dat        data memory interface
// Build option: DMEM_LSU_MISALIGN_TRAP_EN -- when defined, misaligned half and
// word accesses are rejected with resp_err; otherwise the low address bits
// are forced to alignment and the access proceeds.
// -----------------------------------------------------------------------------
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_dat,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rd_dat
);

  lsu_state_t        state_reg, state_next;
  logic [MEM_AW+1:0] addr_reg;
  logic              we_reg;
  logic [2:0]        f3_reg;
  logic [15:0]       wdata_reg;
  logic [DATA_W-1:0] merged_reg;
  logic              err_reg;

  logic              accept;
  logic              reject;
  logic              misalign_rej;
  logic [1:0]        req_lo;
  logic [MEM_AW+1:0] req_addr_eff;
  logic              is_sw;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged_word;

  // Address bits above the memory depth are deliberately dropped (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_W-1:MEM_AW+2];

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  assign misalign_rej = f3_misaligned(req_funct3, req_addr[1:0]);
  assign req_lo       = req_addr[1:0];
`else
  assign misalign_rej = 1'b0;
  assign req_lo       = f3_align_lo(req_funct3, req_addr[1:0]);
`endif

  assign reject       = !f3_legal(req_we, req_funct3) || misalign_rej;
  assign req_addr_eff = {req_addr[MEM_AW+1:2], req_lo};
  assign accept       = req_valid && req_ready;
  assign is_sw        = req_we && (req_funct3 == F3_W);

  dmem_lane_align u_align (
    .word     (mem_rd_dat),
    .addr_lo  (addr_reg[1:0]),
    .funct3   (f3_reg),
    .wdata    (wdata_reg),
    .load_val (load_val),
    .merged   (merged_word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (reject || is_sw) ? DONE : LD_WAIT;
      LD_WAIT: state_next = we_reg ? RMW_WR : IDLE;
      RMW_WR:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All outputs are forced low while rst is high, which is also what
  // suppresses a pending RMW write when reset lands in RMW_WR.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_addr   = '0;
    mem_wr_dat = '0;
    mem_wr_en  = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          req_ready = 1'b1;
          mem_addr  = req_addr[MEM_AW+1:2];
          if (req_valid && !reject && is_sw) begin
            mem_wr_dat = req_wdata;
            mem_wr_en  = 1'b1;
          end
        end
        LD_WAIT: begin
          mem_addr = addr_reg[MEM_AW+1:2];
          if (!we_reg) begin
            resp_valid = 1'b1;
            resp_rdata = load_val;
          end
        end
        RMW_WR: begin
          mem_addr   = addr_reg[MEM_AW+1:2];
          mem_wr_dat = merged_reg;
          mem_wr_en  = 1'b1;
        end
        DONE: begin
          mem_addr   = addr_reg[MEM_AW+1:2];
          resp_valid = 1'b1;
          resp_err   = err_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      f3_reg     <= '0;
      wdata_reg  <= '0;
      merged_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= req_addr_eff;
        we_reg    <= req_we;
        f3_reg    <= req_funct3;
        wdata_reg <= req_wdata[15:0];
        err_reg   <= reject;
      end
      if (state_reg == LD_WAIT && we_reg) merged_reg <= merged_word;
    end
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Load/store sequencer between the core's memory-stage request and the word-wide data memory. The data memory is synchronous: a write lands on the clock edge and the read data is registered, so it is valid one cycle after the address. This block does the following:
- maps byte addresses to word addresses;
- performs read-modify-write for sub-word stores;
- selects and sign- or zero-extends sub-word loads;
- stalls the core through a valid/ready handshake.

Parameters:
ADDR_W, 32, byte-address width of core request
MEM_AW, 10, word-address width driven to data memory (memory depth = 2**MEM_AW words)
DATA_W, 32, data width; fixed at 32 (4 byte lanes), other values unsupported

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  core presents an access
req_ready  out  1  block can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I size/sign code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  extended load data, valid with resp_valid on loads; 0 otherwise
resp_err  out  1  access rejected, valid with resp_valid (see Optional Feature)
mem_addr  out  MEM_AW  word address to data memory
mem_wr_dat  out  32  write data to data memory
mem_wr_en  out  1  write strobe to data memory
mem_rd_dat  in  32  registered read data, valid the cycle after mem_addr is driven

Behaviour:
- Clock port is clk; reset is rst, which is synchronous and active-high. rst forces state=IDLE and clears latched request registers. While rst is high: resp_valid=0, resp_err=0, resp_rdata=0, mem_wr_en=0, mem_addr=0, mem_wr_dat=0. req_ready=0 while rst is high.
- Handshake: an access is accepted in a cycle where req_valid && req_ready. On acceptance, we/funct3/addr/wdata are latched. req_valid in any non-IDLE state is ignored (not queued). Exactly one resp_valid pulse is produced per accepted access.
- Word address: mem_addr = addr[MEM_AW+1:2]. Upper bits are ignored, so the address wraps modulo the memory size.
- States: IDLE, LD_WAIT, RMW_WR, DONE.
- IDLE, on acceptance of a load or a sub-word store: drive mem_addr from req_addr, mem_wr_en=0, go to LD_WAIT.
- IDLE, on acceptance of SW: drive mem_addr, mem_wr_dat=req_wdata, mem_wr_en=1, go to DONE.
- LD_WAIT, load: resp_valid=1. resp_rdata = lane from mem_rd_dat selected by addr[1:0] (byte) or addr[1] (half), sign-extended (000/001) or zero-extended (100/101); LW passes the word through. Go to IDLE. Load latency: accept at cycle N, resp at N+1.
- LD_WAIT, sub-word store: capture merged word = mem_rd_dat with the addressed byte or half replaced by wdata[7:0] or wdata[15:0]. Go to RMW_WR.
- RMW_WR: drive latched mem_addr, mem_wr_dat=merged word, mem_wr_en=1. Go to DONE. SB/SH: accept at N, resp at N+3.
- DONE: resp_valid=1, resp_rdata=0. Go to IDLE. SW: accept at N, resp at N+1.
- mem_wr_en is high in exactly one cycle per store and never for loads.
- req_ready = (state==IDLE) && !rst. The earliest back-to-back acceptance is the cycle after resp_valid.
- Illegal funct3 (011, 110, 111; or 100/101 with req_we=1): complete as in DONE with no memory access and resp_err=1.
- Reset mid-operation: the access is abandoned and no response is given. If rst rises in RMW_WR, the write is suppressed, leaving the memory word unchanged.

Optional Feature:
Macro: DMEM_LSU_MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 goes to DONE without a memory access. resp_err=1, resp_rdata=0.
- Undefined: the misaligned low address bits are forced to zero (half: addr[0]; word: addr[1:0]) and the access proceeds normally. resp_err is then driven only by the illegal-funct3 rule.

Decomposition:
- Package dmem_lsu_pkg contains:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum typedef lsu_state_t {IDLE, LD_WAIT, RMW_WR, DONE};
  - a size/misalign helper function.
- Sub-module dmem_lane_align (combinational): given word, addr[1:0], funct3 and store data, produces the extended load value and the merged store word. It is shared by the load path and the RMW path.

Test Plan:
- Preload word 0x8 = 0x80FF7F01. LB @0x0B -> resp_rdata=0xFFFFFF80 at N+1. LBU @0x0B -> 0x00000080.
- SB 0xA5 @0x09 on word 0x8 = 0x11223344 -> one mem_wr_en pulse at N+2 with mem_wr_dat=0x1122A544; resp_valid at N+3. Then LW @0x08 -> 0x1122A544.
- SW 0xDEADBEEF @0x10, then an immediate req_valid held high -> second request accepted only when req_ready=1 after resp. mem_wr_en high exactly one cycle.
- LH @0x06 with word 0x4 = 0x8001xxxx -> 0xFFFF8001. Also, with MEM_AW=10, an address of 0x1004 must hit word 1.
- rst asserted in RMW_WR of SH @0x20 -> no mem_wr_en, no resp_valid; a subsequent LW @0x20 returns the original value.
- LW @0x02: with the macro -> resp_err=1, no memory access. Without the macro -> reads word 0x0, resp_err=0. funct3=011 -> resp_err=1 in both builds.
